oven_counter: RTL and testbench

- Cooking-time counter that sits opposite ctrl_oven on its count interface.
- Consumes ctrl_oven's start_count/stop_count and the user time selection (s30/s60/s120/time_set); returns timeout to ctrl_oven.
- Replaces the behavioural counter model used in the controller bench; instantiated beside ctrl_oven in top.
- Counts down the selected duration in ticks, pauses on stop_count (door open), resumes on start_count, and pulses timeout on expiry.

---
 rtl/oven_pkg.sv | 27 ++
 rtl/oven_tick_gen.sv | 32 +++
 rtl/oven_counter.sv | 112 +++++++++++
 tb/tb_oven_counter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/oven_pkg.sv
// Shared types and constants for the oven cooking-time counter.
package oven_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOADED,
    ST_RUN,
    ST_HOLD,
    ST_DONE
  } oven_cnt_state_t;

  localparam int unsigned T30  = 30;
  localparam int unsigned T60  = 60;
  localparam int unsigned T120 = 120;

  localparam int unsigned CYCLES_PER_SEC_DEFAULT = 1;

  // Longest selection wins; zero means no selection.
  function automatic int unsigned preset_of(input logic s30, input logic s60,
                                            input logic s120);
    if (s120)     return T120;
    else if (s60) return T60;
    else if (s30) return T30;
    else          return 0;
  endfunction

endpackage

// File: rtl/oven_tick_gen.sv
// Seconds prescaler: pulses tick on the enabled edge that wraps the phase counter.
module oven_tick_gen #(
  parameter int unsigned CYCLES_PER_SEC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick,
  output logic at_wrap
);

  // A one-bit counter that never leaves 0 covers CYCLES_PER_SEC=1 (tick == en).
  localparam int unsigned PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;

  logic [PW-1:0] pre_q, pre_d;

  assign at_wrap = (pre_q == PW'(CYCLES_PER_SEC - 1));
  assign tick    = en && at_wrap;

  always_comb begin
    pre_d = pre_q;
    if (clear)        pre_d = '0;
    else if (en)      pre_d = at_wrap ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end

endmodule

// File: rtl/oven_counter.sv
// Cooking-time down counter paired with ctrl_oven: load, run, pause, expire.
module oven_counter
  import oven_pkg::*;
#(
  parameter int unsigned CYCLES_PER_SEC = CYCLES_PER_SEC_DEFAULT,
  parameter int unsigned CNT_W          = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s30,
  input  logic             s60,
  input  logic             s120,
  input  logic             time_set,
  input  logic             start_count,
  input  logic             stop_count,
  output logic             timeout,
  output logic [CNT_W-1:0] remaining,
  output logic             counting,
  output logic             paused
);

  oven_cnt_state_t  state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] preset;
  logic             timeout_q, counting_q, paused_q;
  logic             load, adv, tick, at_wrap, last_tick;

  assign preset    = CNT_W'(preset_of(s30, s60, s120));
  assign last_tick = (rem_q == CNT_W'(1)) && at_wrap;

  oven_tick_gen #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (adv),
    .clear  (load),
    .tick   (tick),
    .at_wrap(at_wrap)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (time_set && preset != '0) begin
          load    = 1'b1;
          state_d = ST_LOADED;
        end
      end
      ST_LOADED: begin
        if (!time_set) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end else begin
          load = (preset != '0);
          if (start_count && !stop_count) state_d = ST_RUN;
        end
      end
      // stop_count is ignored on the edge that delivers the final tick
      ST_RUN: begin
        if (!stop_count || last_tick) adv = 1'b1;
        else                          state_d = ST_HOLD;
      end
      // The resuming edge counts, so HOLD costs exactly its stop cycles
      ST_HOLD: begin
        if (start_count && !stop_count) begin
          adv     = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end
    endcase
    if (load) rem_d = preset;
    if (tick && rem_q != '0) begin
      rem_d = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      timeout_q  <= 1'b0;
      counting_q <= 1'b0;
      paused_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      timeout_q  <= (state_d == ST_DONE);
      counting_q <= (state_d == ST_RUN);
      paused_q   <= (state_d == ST_HOLD);
    end
  end

  assign timeout   = timeout_q;
  assign remaining = rem_q;
  assign counting  = counting_q;
  assign paused    = paused_q;

endmodule

// File: tb/tb_oven_counter.sv
// Directed bench for oven_counter at CYCLES_PER_SEC=1 and 4 against a behavioural model.
module tb_oven_counter;

  logic clk = 1'b0;
  logic reset = 1'b0, s30 = 1'b0, s60 = 1'b0, s120 = 1'b0;
  logic time_set = 1'b0, start_count = 1'b0, stop_count = 1'b0;

  logic       to_o  [2];
  logic [6:0] rem_o [2];
  logic       cnt_o [2];
  logic       pau_o [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  oven_counter #(.CYCLES_PER_SEC(1), .CNT_W(7)) dut1 (
    .clk(clk), .reset(reset), .s30(s30), .s60(s60), .s120(s120),
    .time_set(time_set), .start_count(start_count), .stop_count(stop_count),
    .timeout(to_o[0]), .remaining(rem_o[0]), .counting(cnt_o[0]), .paused(pau_o[0])
  );

  oven_counter #(.CYCLES_PER_SEC(4), .CNT_W(7)) dut4 (
    .clk(clk), .reset(reset), .s30(s30), .s60(s60), .s120(s120),
    .time_set(time_set), .start_count(start_count), .stop_count(stop_count),
    .timeout(to_o[1]), .remaining(rem_o[1]), .counting(cnt_o[1]), .paused(pau_o[1])
  );

  // Model: mode 0 idle, 1 loaded, 2 run, 3 hold, 4 done; sec = seconds left,
  // cyc = cycles already spent in the current second.
  int cps [2] = '{1, 4};
  int mode[2], sec[2], cyc[2];
  bit armed = 1'b0;

  function automatic int sel_secs();
    if (s120) return 120;
    if (s60)  return 60;
    if (s30)  return 30;
    return 0;
  endfunction

  task automatic cmp(input string name, input int d, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0d, want %0d", name, d, $time, got, want);
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mode[d] = 0; sec[d] = 0; cyc[d] = 0;
      end else begin
        case (mode[d])
          0: if (time_set && sel_secs() != 0) begin
               mode[d] = 1; sec[d] = sel_secs(); cyc[d] = 0;
             end
          1: if (!time_set) begin
               mode[d] = 0; sec[d] = 0;
             end else begin
               if (sel_secs() != 0) begin sec[d] = sel_secs(); cyc[d] = 0; end
               if (start_count && !stop_count) mode[d] = 2;
             end
          2, 3: begin
            bit finishing, spend;
            finishing = (sec[d] == 1) && (cyc[d] == cps[d] - 1);
            spend = (mode[d] == 2) ? (!stop_count || finishing)
                                   : (start_count && !stop_count);
            if (spend) begin
              mode[d] = 2;
              cyc[d]++;
              if (cyc[d] == cps[d]) begin
                cyc[d] = 0;
                sec[d]--;
                if (sec[d] == 0) mode[d] = 4;
              end
            end else if (mode[d] == 2) begin
              mode[d] = 3;
            end
          end
          default: begin mode[d] = 0; sec[d] = 0; end
        endcase
      end
    end
    if (reset) armed = 1'b1;
    #1;
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        cmp("timeout",   d, int'(to_o[d]),  int'(mode[d] == 4));
        cmp("remaining", d, int'(rem_o[d]), sec[d]);
        cmp("counting",  d, int'(cnt_o[d]), int'(mode[d] == 2));
        cmp("paused",    d, int'(pau_o[d]), int'(mode[d] == 3));
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; s30 = 0; s60 = 0; s120 = 0;
    time_set = 0; start_count = 0; stop_count = 0;
    step(2);
    reset = 1'b0;
  endtask

  // Load a selection and start: returns just after edge E0.
  task automatic load_start(input logic a30, input logic a60, input logic a120);
    s30 = a30; s60 = a60; s120 = a120; time_set = 1'b1;
    step();
    start_count = 1'b1;
    step();
    time_set = 1'b0; s30 = 0; s60 = 0; s120 = 0;
  endtask

  initial begin
    step();
    // s30, one tick per cycle
    do_reset();
    cmp("rst_rem", 0, int'(rem_o[0]), 0);
    cmp("rst_cnt", 0, int'(cnt_o[0]), 0);
    load_start(1, 0, 0);
    cmp("e0_rem", 0, int'(rem_o[0]), 30);
    step();
    cmp("e1_rem", 0, int'(rem_o[0]), 29);
    step(28);
    cmp("e29_to", 0, int'(to_o[0]), 0);
    step();
    cmp("e30_to", 0, int'(to_o[0]), 1);
    cmp("e30_rem", 0, int'(rem_o[0]), 0);
    step();
    cmp("e31_to", 0, int'(to_o[0]), 0);
    cmp("e31_cnt", 0, int'(cnt_o[0]), 0);

    // s60 with a 10-cycle pause after 20 counts
    do_reset();
    load_start(0, 1, 0);
    step(20);
    cmp("p_rem40", 0, int'(rem_o[0]), 40);
    stop_count = 1'b1;
    step();
    cmp("p_paused", 0, int'(pau_o[0]), 1);
    step(9);
    cmp("p_hold40", 0, int'(rem_o[0]), 40);
    stop_count = 1'b0;
    step();
    cmp("p_resume", 0, int'(rem_o[0]), 39);
    step(38);
    cmp("p_e69_to", 0, int'(to_o[0]), 0);
    step();
    cmp("p_e70_to", 0, int'(to_o[0]), 1);
    start_count = 1'b0;
    step(2);

    // All selects high, then time_set dropped while loaded
    do_reset();
    s30 = 1; s60 = 1; s120 = 1; time_set = 1;
    step();
    cmp("prio_120", 0, int'(rem_o[0]), 120);
    time_set = 0;
    step();
    cmp("drop_rem", 0, int'(rem_o[0]), 0);
    s30 = 0; s60 = 0; s120 = 0;
    step();

    // Reset mid-run
    do_reset();
    load_start(0, 0, 1);
    step(70);
    cmp("r_rem50", 0, int'(rem_o[0]), 50);
    reset = 1'b1;
    step();
    reset = 1'b0; start_count = 1'b0;
    cmp("r_rem0", 0, int'(rem_o[0]), 0);
    cmp("r_cnt0", 0, int'(cnt_o[0]), 0);
    step(60);

    // start+stop together in LOADED, then stop rising on the final tick
    do_reset();
    s30 = 1; time_set = 1; start_count = 1; stop_count = 1;
    step(5);
    cmp("ss_rem", 0, int'(rem_o[0]), 30);
    cmp("ss_cnt", 0, int'(cnt_o[0]), 0);
    stop_count = 1'b0;
    step();
    time_set = 0; s30 = 0;
    step(29);
    cmp("ft_rem1", 0, int'(rem_o[0]), 1);
    stop_count = 1'b1;
    step();
    cmp("ft_to", 0, int'(to_o[0]), 1);
    cmp("ft_pau", 0, int'(pau_o[0]), 0);
    stop_count = 1'b0; start_count = 1'b0;
    step(3);

    // Four cycles per second with a pause one cycle into a second
    do_reset();
    load_start(1, 0, 0);
    step(3);
    cmp("c4_e3", 1, int'(rem_o[1]), 30);
    step();
    cmp("c4_e4", 1, int'(rem_o[1]), 29);
    step();
    stop_count = 1'b1;
    step(3);
    stop_count = 1'b0;
    step(2);
    cmp("c4_e10", 1, int'(rem_o[1]), 29);
    step();
    cmp("c4_e11", 1, int'(rem_o[1]), 28);
    step(111);
    cmp("c4_e122", 1, int'(to_o[1]), 0);
    step();
    cmp("c4_e123", 1, int'(to_o[1]), 1);
    start_count = 1'b0;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
